// File: rtl/seg_scan_8.sv
// Eight-digit multiplexed common-anode seven-segment driver with per-frame snapshot.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_8 #(
    parameter int CNT_MAX = 50000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] t_tho,
    input  logic [3:0] h_hun,
    input  logic [3:0] mil,
    input  logic [3:0] t_mil,
    input  logic [7:0] point,
    input  logic       seg_en,
    output logic [7:0] sel,
    output logic [7:0] seg,
    output logic       frame_tick
);

    localparam int CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_scan;
    logic [2:0]       idx;
    logic [3:0]       snap_dig [8];
    logic [7:0]       snap_pt;
    logic [3:0]       dig_in   [8];
    logic             tick;
    logic             frame_end;
    logic             blank;
    logic [7:0]       sel_nxt;
    logic [7:0]       seg_nxt;

    function automatic logic [6:0] dec7(input logic [3:0] d);
        case (d)
            4'd0:    dec7 = 7'h40;
            4'd1:    dec7 = 7'h79;
            4'd2:    dec7 = 7'h24;
            4'd3:    dec7 = 7'h30;
            4'd4:    dec7 = 7'h19;
            4'd5:    dec7 = 7'h12;
            4'd6:    dec7 = 7'h02;
            4'd7:    dec7 = 7'h78;
            4'd8:    dec7 = 7'h00;
            4'd9:    dec7 = 7'h10;
            default: dec7 = 7'h3F;
        endcase
    endfunction

    assign dig_in[0] = unit;
    assign dig_in[1] = ten;
    assign dig_in[2] = hun;
    assign dig_in[3] = tho;
    assign dig_in[4] = t_tho;
    assign dig_in[5] = h_hun;
    assign dig_in[6] = mil;
    assign dig_in[7] = t_mil;

    assign tick      = (cnt_scan == CNT_LAST);
    assign frame_end = tick && (idx == 3'd7);

`ifdef SEG_LZB_EN
    logic [7:0] blank_mask;
    logic [7:0] blank_nxt;
    logic       zero_run;

    // A digit blanks only if it and every higher digit are zero with no point lit.
    always_comb begin
        zero_run  = 1'b1;
        blank_nxt = 8'h00;
        for (int i = 7; i >= 1; i--) begin
            zero_run     = zero_run && (dig_in[i] == 4'd0) && !point[i];
            blank_nxt[i] = zero_run;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            blank_mask <= 8'hFE;
        else if (frame_end)
            blank_mask <= blank_nxt;
    end

    assign blank = blank_mask[idx];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        sel_nxt = 8'hFF;
        seg_nxt = 8'hFF;
        if (seg_en) begin
            sel_nxt = ~(8'd1 << idx);
            if (!blank)
                seg_nxt = {~snap_pt[idx], dec7(snap_dig[idx])};
        end
    end

    // Scan counters, frame snapshot, and registered display outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_scan   <= '0;
            idx        <= 3'd0;
            frame_tick <= 1'b0;
            snap_pt    <= 8'h00;
            sel        <= 8'hFF;
            seg        <= 8'hFF;
            for (int i = 0; i < 8; i++)
                snap_dig[i] <= 4'd0;
        end else begin
            cnt_scan   <= tick ? '0 : cnt_scan + CNT_ONE;
            frame_tick <= frame_end;
            sel        <= sel_nxt;
            seg        <= seg_nxt;
            if (tick)
                idx <= idx + 3'd1;
            if (frame_end) begin
                snap_pt <= point;
                for (int i = 0; i < 8; i++)
                    snap_dig[i] <= dig_in[i];
            end
        end
    end

endmodule
